// File: rtl/add_share_arbiter_pkg.sv
// add_share_pkg: shared constants and the round-robin step helper
// used by the add_share_arbiter block and its rr_pick sub-module.
package add_share_pkg;

   // Default operand/result width of the shared adder.
   localparam int DEF_WIDTH = 32;

   // Largest supported number of requesters.
   localparam int MAX_REQ = 8;

   // Next index after idx, wrapping modulo n.
   function automatic int next_rr(input int idx, input int n);
      if (idx + 1 >= n) begin
         return 0;
      end
      return idx + 1;
   endfunction

endpackage

// File: rtl/add_share_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker. Searches upward from
// the slot after last, wrapping modulo N, for the first eligible index.
// Ports:
//   elig  in  N     eligible requesters
//   last  in  ID_W  index of the previous grant
//   gnt   out N     one-hot grant (all zero when nothing is eligible)
//   idx   out ID_W  encoded winner index
//   any   out 1     a winner exists
module rr_pick
   import add_share_pkg::*;
#(
   parameter int N    = 3,
   parameter int ID_W = 2
) (
   input  logic [N-1:0]    elig,
   input  logic [ID_W-1:0] last,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] idx,
   output logic            any
);

   always_comb begin
      int pos;
      gnt = '0;
      idx = '0;
      any = 1'b0;
      pos = int'(last);
      // Visit candidates in priority order: last+1, last+2, ... last.
      for (int k = 0; k < N; k++) begin
         pos = next_rr(pos, N);
         for (int j = 0; j < N; j++) begin
            if (!any && (j == pos) && elig[j]) begin
               any    = 1'b1;
               gnt[j] = 1'b1;
               idx    = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/add_share_arbiter.sv
// add_share_arbiter: one WIDTH-bit adder shared by NUM_REQ requesters
// with round-robin arbitration and a one-entry result buffer per requester.
// Optional macro ADD_SHARE_ARBITER_OVF_EN adds the rsp_ovf port.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_valid/req_ready request handshake, one bit per requester
//   req_lhs/req_rhs     packed operands, requester i at [i*WIDTH +: WIDTH]
//   rsp_valid/rsp_ready response handshake, one bit per requester
//   rsp_sum             packed held sums
//   last_grant          index of the most recent grant
//   rsp_ovf             held signed-overflow flags (macro only)
module add_share_arbiter
   import add_share_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int ID_W    = 2,
   parameter int WIDTH   = DEF_WIDTH
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [NUM_REQ-1:0]         req_valid,
   output logic [NUM_REQ-1:0]         req_ready,
   input  logic [NUM_REQ*WIDTH-1:0]   req_lhs,
   input  logic [NUM_REQ*WIDTH-1:0]   req_rhs,
   output logic [NUM_REQ-1:0]         rsp_valid,
   input  logic [NUM_REQ-1:0]         rsp_ready,
   output logic [NUM_REQ*WIDTH-1:0]   rsp_sum,
   output logic [ID_W-1:0]            last_grant
`ifdef ADD_SHARE_ARBITER_OVF_EN
   ,
   output logic [NUM_REQ-1:0]         rsp_ovf
`endif
);

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] gnt;
   logic [ID_W-1:0]    gnt_idx;
   logic               gnt_any;
   logic [WIDTH-1:0]   sel_lhs;
   logic [WIDTH-1:0]   sel_rhs;
   logic [WIDTH-1:0]   sum;
   logic               ovf;

   // A slot may refill while it drains in the same cycle. Nothing is
   // eligible during reset so no handshake completes then.
   assign elig = req_valid
               & (~rsp_valid | rsp_ready)
               & {NUM_REQ{rst_n}};

   rr_pick #(
      .N    (NUM_REQ),
      .ID_W (ID_W)
   ) u_pick (
      .elig (elig),
      .last (last_grant),
      .gnt  (gnt),
      .idx  (gnt_idx),
      .any  (gnt_any)
   );

   assign req_ready = gnt;

   // One-hot AND-OR operand mux; keeps req_ready independent of data.
   always_comb begin
      sel_lhs = '0;
      sel_rhs = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         sel_lhs = sel_lhs | ({WIDTH{gnt[i]}} & req_lhs[i*WIDTH +: WIDTH]);
         sel_rhs = sel_rhs | ({WIDTH{gnt[i]}} & req_rhs[i*WIDTH +: WIDTH]);
      end
   end

   assign sum = sel_lhs + sel_rhs;

   // Signed overflow: operands agree in sign, result does not.
   assign ovf = (sel_lhs[WIDTH-1] == sel_rhs[WIDTH-1])
             && (sum[WIDTH-1] != sel_lhs[WIDTH-1]);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid  <= '0;
         rsp_sum    <= '0;
         last_grant <= ID_W'(NUM_REQ - 1);
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
               rsp_valid[i]                <= 1'b1;
               rsp_sum[i*WIDTH +: WIDTH]   <= sum;
            end else if (rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
         if (gnt_any) begin
            last_grant <= gnt_idx;
         end
      end
   end

`ifdef ADD_SHARE_ARBITER_OVF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_ovf <= '0;
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
               rsp_ovf[i] <= ovf;
            end else if (rsp_ready[i]) begin
               rsp_ovf[i] <= 1'b0;
            end
         end
      end
   end
`else
   logic unused_ovf;
   assign unused_ovf = ovf;
`endif

endmodule

// File: tb/tb_add_share_arbiter.sv
// tb_add_share_arbiter: directed checks of add_share_arbiter with
// NUM_REQ=3, WIDTH=32. Honours ADD_SHARE_ARBITER_OVF_EN when defined.
module tb_add_share_arbiter;

   localparam int N = 3;
   localparam int W = 32;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req_valid;
   logic [N-1:0]   req_ready;
   logic [N*W-1:0] req_lhs;
   logic [N*W-1:0] req_rhs;
   logic [N-1:0]   rsp_valid;
   logic [N-1:0]   rsp_ready;
   logic [N*W-1:0] rsp_sum;
   logic [1:0]     last_grant;
`ifdef ADD_SHARE_ARBITER_OVF_EN
   logic [N-1:0]   rsp_ovf;
`endif

   int total;
   int bad;

   add_share_arbiter #(
      .NUM_REQ (N),
      .ID_W    (2),
      .WIDTH   (W)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_lhs    (req_lhs),
      .req_rhs    (req_rhs),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_sum    (rsp_sum),
      .last_grant (last_grant)
`ifdef ADD_SHARE_ARBITER_OVF_EN
      ,
      .rsp_ovf    (rsp_ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_lhs   = '0;
      req_rhs   = '0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      rst_n     = 1'b0;
      req_valid = 3'b111;
      rsp_ready = 3'b111;
      req_lhs   = '0;
      req_rhs   = '0;
      req_lhs[0 +: W] = 32'd5;
      req_rhs[0 +: W] = 32'd6;
      tick();
      tick();
      @(negedge clk);
      total++;
      if (req_ready !== 3'b000) begin
         bad++;
         $display("FAIL reset_ready got=%b exp=000", req_ready);
      end
      total++;
      if (rsp_valid !== 3'b000) begin
         bad++;
         $display("FAIL reset_rsp_valid got=%b exp=000", rsp_valid);
      end
      total++;
      if (last_grant !== 2'd2) begin
         bad++;
         $display("FAIL reset_last_grant got=%0d exp=2", last_grant);
      end
      total++;
      if (rsp_sum !== '0) begin
         bad++;
         $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum);
      end
`ifdef ADD_SHARE_ARBITER_OVF_EN
      total++;
      if (rsp_ovf !== 3'b000) begin
         bad++;
         $display("FAIL reset_ovf got=%b exp=000", rsp_ovf);
      end
`endif
      tick();
      rst_n = 1'b1;
      @(negedge clk);
      total++;
      if (req_ready !== 3'b001) begin
         bad++;
         $display("FAIL reset_first_grant got=%b exp=001", req_ready);
      end
      tick();
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_sum[0 +: W] !== 32'd11) begin
         bad++;
         $display("FAIL reset_first_rsp got=%b/%h exp=1/0000000b",
                  rsp_valid[0], rsp_sum[0 +: W]);
      end
      total++;
      if (last_grant !== 2'd0) begin
         bad++;
         $display("FAIL reset_first_last got=%0d exp=0", last_grant);
      end
      req_valid = '0;
   endtask

   task automatic test_single();
      do_reset();
      req_valid = 3'b010;
      rsp_ready = 3'b111;
      req_lhs[1*W +: W] = 32'h0000_1000;
      req_rhs[1*W +: W] = 32'h0000_0004;
      @(negedge clk);
      total++;
      if (req_ready !== 3'b010) begin
         bad++;
         $display("FAIL single_ready got=%b exp=010", req_ready);
      end
      tick();
      req_valid = '0;
      total++;
      if (rsp_valid !== 3'b010 || rsp_sum[1*W +: W] !== 32'h0000_1004) begin
         bad++;
         $display("FAIL single_rsp got=%b/%h exp=010/00001004",
                  rsp_valid, rsp_sum[1*W +: W]);
      end
      total++;
      if (last_grant !== 2'd1) begin
         bad++;
         $display("FAIL single_last got=%0d exp=1", last_grant);
      end
      tick();
      total++;
      if (rsp_valid !== 3'b000) begin
         bad++;
         $display("FAIL single_drain got=%b exp=000", rsp_valid);
      end
      total++;
      if (last_grant !== 2'd1) begin
         bad++;
         $display("FAIL idle_last_hold got=%0d exp=1", last_grant);
      end
   endtask

   task automatic test_round_robin();
      logic [N-1:0] exp_rdy;
      logic [W-1:0] exp_sum;
      int e;
      do_reset();
      req_valid = 3'b111;
      rsp_ready = 3'b111;
      for (int k = 0; k < 6; k++) begin
         for (int i = 0; i < N; i++) begin
            req_lhs[i*W +: W] = 32'h100 * (k + 1) + i;
            req_rhs[i*W +: W] = 32'(k);
         end
         e       = k % 3;
         exp_rdy = 3'(1 << e);
         exp_sum = 32'h100 * (k + 1) + 32'(e) + 32'(k);
         @(negedge clk);
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL rr_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy);
         end
         tick();
         total++;
         if (last_grant !== 2'(e) || rsp_valid[e] !== 1'b1
             || rsp_sum[e*W +: W] !== exp_sum) begin
            bad++;
            $display("FAIL rr_rsp[%0d] got=%0d/%b/%h exp=%0d/1/%h",
                     k, last_grant, rsp_valid[e], rsp_sum[e*W +: W], e, exp_sum);
         end
      end
      req_valid = '0;
   endtask

   task automatic test_back_pressure();
      logic [N-1:0] exp_rdy;
      do_reset();
      req_valid = 3'b001;
      rsp_ready = 3'b111;
      req_lhs[0 +: W] = 32'hAAAA_0000;
      req_rhs[0 +: W] = 32'h0000_5555;
      tick();
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_sum[0 +: W] !== 32'hAAAA_5555) begin
         bad++;
         $display("FAIL bp_load got=%b/%h exp=1/aaaa5555",
                  rsp_valid[0], rsp_sum[0 +: W]);
      end
      rsp_ready = 3'b110;
      req_valid = 3'b111;
      req_lhs[0 +: W] = 32'h0000_0001;
      for (int k = 0; k < 4; k++) begin
         exp_rdy = (k % 2 == 0) ? 3'b010 : 3'b100;
         @(negedge clk);
         total++;
         if (req_ready !== exp_rdy) begin
            bad++;
            $display("FAIL bp_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy);
         end
         tick();
         total++;
         if (rsp_valid[0] !== 1'b1 || rsp_sum[0 +: W] !== 32'hAAAA_5555) begin
            bad++;
            $display("FAIL bp_hold[%0d] got=%b/%h exp=1/aaaa5555",
                     k, rsp_valid[0], rsp_sum[0 +: W]);
         end
      end
      rsp_ready = 3'b111;
      req_lhs[0 +: W] = 32'd1;
      req_rhs[0 +: W] = 32'd2;
      @(negedge clk);
      total++;
      if (req_ready !== 3'b001) begin
         bad++;
         $display("FAIL bp_refill_ready got=%b exp=001", req_ready);
      end
      tick();
      req_valid = '0;
      total++;
      if (rsp_valid[0] !== 1'b1 || rsp_sum[0 +: W] !== 32'd3) begin
         bad++;
         $display("FAIL bp_refill got=%b/%h exp=1/00000003",
                  rsp_valid[0], rsp_sum[0 +: W]);
      end
   endtask

   task automatic test_wrap();
      logic [W-1:0] lhs_t [3];
      logic [W-1:0] rhs_t [3];
      logic [W-1:0] sum_t [3];
      logic         ovf_t [3];
      lhs_t = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      rhs_t = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000};
      sum_t = '{32'h8000_0000, 32'h0000_0000, 32'h0000_0000};
      ovf_t = '{1'b1, 1'b0, 1'b1};
      do_reset();
      req_valid = 3'b001;
      rsp_ready = 3'b111;
      for (int k = 0; k < 3; k++) begin
         req_lhs[0 +: W] = lhs_t[k];
         req_rhs[0 +: W] = rhs_t[k];
         tick();
         total++;
         if (rsp_valid[0] !== 1'b1 || rsp_sum[0 +: W] !== sum_t[k]) begin
            bad++;
            $display("FAIL wrap_sum[%0d] got=%b/%h exp=1/%h",
                     k, rsp_valid[0], rsp_sum[0 +: W], sum_t[k]);
         end
`ifdef ADD_SHARE_ARBITER_OVF_EN
         total++;
         if (rsp_ovf[0] !== ovf_t[k]) begin
            bad++;
            $display("FAIL wrap_ovf[%0d] got=%b exp=%b", k, rsp_ovf[0], ovf_t[k]);
         end
`else
         if (ovf_t[k] === 1'bx) begin
            $display("note: undefined overflow entry %0d", k);
         end
`endif
      end
      req_valid = '0;
   endtask

   task automatic test_reset_mid();
      do_reset();
      req_valid = 3'b100;
      rsp_ready = 3'b000;
      req_lhs[2*W +: W] = 32'h0000_1234;
      req_rhs[2*W +: W] = 32'h0000_0001;
      tick();
      total++;
      if (rsp_valid !== 3'b100 || rsp_sum[2*W +: W] !== 32'h0000_1235
          || last_grant !== 2'd2) begin
         bad++;
         $display("FAIL mid_grant got=%b/%h/%0d exp=100/00001235/2",
                  rsp_valid, rsp_sum[2*W +: W], last_grant);
      end
      rst_n     = 1'b0;
      req_valid = 3'b011;
      tick();
      total++;
      if (rsp_valid !== 3'b000 || rsp_sum !== '0 || last_grant !== 2'd2) begin
         bad++;
         $display("FAIL mid_reset got=%b/%h/%0d exp=000/0/2",
                  rsp_valid, rsp_sum, last_grant);
      end
      rst_n     = 1'b1;
      req_valid = '0;
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      req_lhs   = '0;
      req_rhs   = '0;
      tick();
      test_reset();
      test_single();
      test_round_robin();
      test_back_pressure();
      test_wrap();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/add_share_arbiter.md
Name: add_share_arbiter

Overview:
- Shares one 32-bit integer adder among NUM_REQ requesters, for example PC+4, branch-target and load/store address generation in the pipelined RV32 core.
- Uses round-robin arbitration with a valid/ready request handshake.
- Each requester has a one-entry registered response buffer, so it can back-pressure its own result without stalling the others.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- ID_W, 2, width of grant index; must satisfy 2^ID_W >= NUM_REQ
- WIDTH, 32, operand/result width

Ports:
- clk  in  1  core clock; all state changes on rising edge
- rst_n  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester request accepted this cycle
- req_lhs  in  NUM_REQ*WIDTH  packed left operands; requester i occupies bits [i*WIDTH +: WIDTH]
- req_rhs  in  NUM_REQ*WIDTH  packed right operands, same packing
- rsp_valid  out  NUM_REQ  per-requester result held
- rsp_ready  in  NUM_REQ  requester consumes its result
- rsp_sum  out  NUM_REQ*WIDTH  packed held sums
- last_grant  out  ID_W  index of the most recent grant (debug/perf)

Behaviour:
- Reset (rst_n low at a clk edge): rsp_valid=0, rsp_sum=0, last_grant=NUM_REQ-1, so requester 0 has first priority after reset. Reset mid-operation discards all held results and any grant made in that cycle.
- Eligibility: requester i is eligible when req_valid[i]=1 AND (rsp_valid[i]=0 OR rsp_ready[i]=1). Draining and refilling a slot in the same cycle is allowed.
- Arbitration: combinational round-robin. Pick the first eligible index after last_grant, searching upward and wrapping modulo NUM_REQ.
- At most one req_ready bit is high per cycle, and only for the winner. req_ready must not depend on req_lhs/req_rhs.
- Grant (req_valid&req_ready): sum = lhs+rhs modulo 2^WIDTH, carry discarded. Sum is registered into rsp_sum[i] and rsp_valid[i]<=1 at that edge; last_grant<=i. Latency is one cycle from accept to rsp_valid.
- Hold: rsp_valid[i] and rsp_sum[i] stay stable until rsp_ready[i]=1. Then rsp_valid[i]<=0, unless the same edge carries a new grant to i, in which case the new sum is loaded and rsp_valid stays 1.
- No eligible requester: no grant, last_grant unchanged.
- Single continuous requester with rsp_ready tied high: one accept per cycle.
- Fairness: with N requesters continuously eligible, each is granted exactly once per N cycles.
- The adder is combinational. Only the response buffers, last_grant and the optional flags are state.

Optional Feature:
- Macro: ADD_SHARE_ARBITER_OVF_EN.
- When defined: adds port rsp_ovf (out, NUM_REQ), the registered signed-overflow flag for each held sum. The flag is 1 when both operand MSBs are equal and the sum MSB differs. It is reset to 0 and held/cleared alongside rsp_valid.
- When undefined: no port and no overflow logic; the remaining behaviour is identical.

Decomposition:
- Package add_share_pkg holds:
  - the default width constant (32)
  - the max-requester constant (8)
  - a function computing the next round-robin index
- One sub-module is natural: rr_pick. It takes an eligible vector and last_grant, and outputs a one-hot grant plus the encoded index. It is purely combinational.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles while req_valid=3'b111 -> req_ready=0, rsp_valid=0, last_grant=2; the first grant after release goes to requester 0.
- Single requester: req 1 with lhs=0x0000_1000, rhs=0x0000_0004, rsp_ready=1 -> req_ready[1]=1 that cycle; next cycle rsp_valid[1]=1, rsp_sum[1]=0x0000_1004.
- Round-robin: all three valid every cycle, rsp_ready=all 1 -> grants 0,1,2,0,1,2 on consecutive cycles; last_grant follows the same sequence.
- Back-pressure: rsp_ready[0]=0 with rsp_valid[0]=1 and req 0 still valid -> req 0 is never granted; reqs 1 and 2 alternate; rsp_sum[0] is unchanged until rsp_ready[0]=1.
- Wrap and overflow: lhs=0x7FFF_FFFF, rhs=1 -> rsp_sum=0x8000_0000, and rsp_ovf=1 with the macro defined. lhs=0xFFFF_FFFF, rhs=1 -> sum=0, ovf=0.
- Reset mid-operation: grant requester 2, assert rst_n=0 on the next edge -> rsp_valid[2]=0, rsp_sum[2]=0, last_grant=2.
